// File: rtl/dpll_pkg.sv
// Shared definitions for the DPLL clock path: minimum divide ratio and the
// high-phase length helper used by the programmable divider.
package dpll_pkg;

  localparam int unsigned DIV_MIN = 2;

  // Number of counter states (starting at 0) during which the posedge
  // register drives clk_o high for ratio n. For odd n with the negedge helper
  // enabled, the helper flop adds the missing half input period.
  function automatic int unsigned half_cnt(input int unsigned n, input bit odd50);
    if (!n[0]) begin
      return n >> 1;
    end else if (odd50) begin
      return (n - 1) >> 1;
    end else begin
      return n >> 1;
    end
  endfunction

endpackage

// File: rtl/clk_div_ratio_ctrl.sv
// Ratio control for clk_div_prog: accepts load requests, holds one pending
// ratio and swaps it into the active ratio at the end of a divider period.
`timescale 1ns/1ps
module clk_div_ratio_ctrl #(
  parameter int CNT_W       = 16,
  parameter int DIV_DEFAULT = 500
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             load_req,
  input  logic [CNT_W-1:0] load_div,
  input  logic             at_end,
  output logic             busy,
  output logic             load_err,
  output logic [CNT_W-1:0] div_cur,
  output logic [CNT_W-1:0] div_nxt
);
  import dpll_pkg::*;

  typedef logic [CNT_W-1:0] div_t;

  localparam div_t MIN_N = div_t'(DIV_MIN);
  localparam div_t DEF_N = div_t'(DIV_DEFAULT);

  div_t pend_div;
  logic load_ok;
  logic apply;

  // A request is taken only when nothing is pending and the ratio is legal.
  assign load_ok = load_req && !busy && (load_div >= MIN_N);
  // The pending ratio lands at the end of the current period, running or stopped.
  assign apply   = at_end && busy;
  // Ratio the counter works with from the next edge on.
  assign div_nxt = apply ? pend_div : div_cur;

  // Pending ratio storage; validity is tracked by busy, so no reset is needed.
  always_ff @(posedge clk_in) begin
    if (load_ok) begin
      pend_div <= load_div;
    end
  end

  // Handshake state, rejection pulse and the active ratio.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      load_err <= 1'b0;
      div_cur  <= DEF_N;
    end else begin
      load_err <= load_req && (busy || (load_div < MIN_N));
      if (apply) begin
        div_cur <= pend_div;
        busy    <= 1'b0;
      end else if (load_ok) begin
        busy    <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider. Ratio changes and stop/start
// take effect only at period boundaries so clk_o never glitches; tick_o marks
// every clk_o rising edge in the clk_in domain.
`timescale 1ns/1ps
module clk_div_prog #(
  parameter int CNT_W       = 16,
  parameter int DIV_DEFAULT = 500,
  parameter int ODD_50      = 1
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [CNT_W-1:0] div_i,
  input  logic             div_load_i,
  output logic             busy_o,
  output logic             div_err_o,
  output logic [CNT_W-1:0] div_cur_o,
  output logic             clk_o,
  output logic             tick_o
);
  import dpll_pkg::*;

  typedef logic [CNT_W-1:0] div_t;

  localparam div_t ONE      = div_t'(1);
  localparam div_t DEF_N    = div_t'(DIV_DEFAULT);
  localparam bit   ODD_HELP = (ODD_50 != 0);

  if ((DIV_DEFAULT < int'(DIV_MIN)) ||
      (longint'(DIV_DEFAULT) > ((longint'(1) << CNT_W) - 1))) begin : g_bad_default
    $error("clk_div_prog: DIV_DEFAULT outside 2..2^CNT_W-1");
  end

  div_t cnt;
  div_t cnt_nxt;
  div_t div_nxt;
  div_t h_nxt;
  logic at_end;
  logic wrap;
  logic clk_p;
  logic clk_n;

  // Last state of the period; it only becomes a wrap if enabled at that moment,
  // otherwise the counter parks here with clk_o low.
  assign at_end = (cnt == (div_cur_o - ONE));
  assign wrap   = at_end && en_i;
  assign h_nxt  = div_t'(half_cnt(32'(div_nxt), ODD_HELP));

  clk_div_ratio_ctrl #(
    .CNT_W       (CNT_W),
    .DIV_DEFAULT (DIV_DEFAULT)
  ) u_ratio_ctrl (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .load_req (div_load_i),
    .load_div (div_i),
    .at_end   (at_end),
    .busy     (busy_o),
    .load_err (div_err_o),
    .div_cur  (div_cur_o),
    .div_nxt  (div_nxt)
  );

  // Next count: restart at 0 on wrap; while stopped, park on the last state of
  // whatever ratio is in effect next (a pending ratio lands while stopped).
  always_comb begin
    cnt_nxt = cnt + ONE;
    if (at_end) begin
      cnt_nxt = en_i ? '0 : (div_nxt - ONE);
    end
  end

  // Counter, posedge phase of the divided clock and the per-period tick.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      cnt    <= DEF_N - ONE;
      clk_p  <= 1'b0;
      tick_o <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      clk_p  <= (cnt_nxt < h_nxt);
      tick_o <= wrap;
    end
  end

  // Half-cycle delayed copy that stretches odd-ratio high phases to N/2 periods.
  always_ff @(negedge clk_in) begin
    if (!rst_n) begin
      clk_n <= 1'b0;
    end else begin
      clk_n <= clk_p;
    end
  end

  assign clk_o = (ODD_HELP && div_cur_o[0]) ? (clk_p | clk_n) : clk_p;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: default ratio timing, odd ratio duty,
// load handshake rejections, stop/start and reset in mid-period.
`timescale 1ns/1ps
module tb_clk_div_prog;
  localparam int CNT_W = 16;

  logic             clk_in = 1'b0;
  logic             rst_n;
  logic             en_i;
  logic [CNT_W-1:0] div_i;
  logic             div_load_i;
  logic             busy_o;
  logic             div_err_o;
  logic [CNT_W-1:0] div_cur_o;
  logic             clk_o;
  logic             tick_o;

  int  tests_run    = 0;
  int  tests_failed = 0;
  int  align_err    = 0;
  time last_rise    = 0;
  time prev_rise    = 0;
  time last_high    = 0;
  time min_high     = 64'd1000000;

  clk_div_prog #(
    .CNT_W       (CNT_W),
    .DIV_DEFAULT (500),
    .ODD_50      (1)
  ) dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .en_i       (en_i),
    .div_i      (div_i),
    .div_load_i (div_load_i),
    .busy_o     (busy_o),
    .div_err_o  (div_err_o),
    .div_cur_o  (div_cur_o),
    .clk_o      (clk_o),
    .tick_o     (tick_o)
  );

  always #10 clk_in = ~clk_in;

  always @(posedge clk_o) begin
    prev_rise = last_rise;
    last_rise = $time;
  end

  always @(negedge clk_o) begin
    last_high = $time - last_rise;
    if (last_high < min_high) min_high = last_high;
  end

  // tick_o must be high exactly in the clk_in cycle that starts with a clk_o rise
  always @(negedge clk_in) begin
    if ($time >= 20 && ((last_rise == $time - 10) != (tick_o === 1'b1))) align_err++;
  end

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic measure_default();
    int fall_at;
    int rise_at;
    int ticks;
    fall_at = -1;
    rise_at = -1;
    ticks   = 0;
    for (int i = 1; i <= 500; i++) begin
      cyc();
      if (tick_o) ticks++;
      if (!clk_o && fall_at < 0) fall_at = i;
      if (clk_o && fall_at >= 0 && rise_at < 0) rise_at = i;
    end
    tests_run++;
    if (fall_at !== 250) begin tests_failed++; $display("FAIL def_fall_cycle: got %0d expected 250", fall_at); end
    tests_run++;
    if (rise_at !== 500) begin tests_failed++; $display("FAIL def_rise_cycle: got %0d expected 500", rise_at); end
    tests_run++;
    if (ticks !== 1) begin tests_failed++; $display("FAIL def_tick_count: got %0d expected 1", ticks); end
    repeat (260) cyc();
    tests_run++;
    if ((last_rise - prev_rise) !== 64'd10000) begin tests_failed++; $display("FAIL def_period_ns: got %0t expected 10000", last_rise - prev_rise); end
    tests_run++;
    if (last_high !== 64'd5000) begin tests_failed++; $display("FAIL def_high_ns: got %0t expected 5000", last_high); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en_i = 1'b1; div_i = '0; div_load_i = 1'b0;
    repeat (3) cyc();
    tests_run++;
    if (clk_o !== 1'b0) begin tests_failed++; $display("FAIL reset_clk_o: got %b expected 0", clk_o); end
    tests_run++;
    if (tick_o !== 1'b0) begin tests_failed++; $display("FAIL reset_tick_o: got %b expected 0", tick_o); end
    tests_run++;
    if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL reset_busy_o: got %b expected 0", busy_o); end
    tests_run++;
    if (div_err_o !== 1'b0) begin tests_failed++; $display("FAIL reset_div_err_o: got %b expected 0", div_err_o); end
    tests_run++;
    if (div_cur_o !== 16'd500) begin tests_failed++; $display("FAIL reset_div_cur_o: got %0d expected 500", div_cur_o); end
    rst_n = 1'b1;
    cyc();
    tests_run++;
    if ({clk_o, tick_o} !== 2'b11) begin tests_failed++; $display("FAIL first_rise: got clk_o=%b tick_o=%b expected 1 1", clk_o, tick_o); end
    measure_default();
    tests_run++;
    if (align_err !== 0) begin tests_failed++; $display("FAIL def_tick_align: got %0d misaligned expected 0", align_err); end
  endtask

  task automatic test_load_odd();
    int n;
    div_i = 16'd3; div_load_i = 1'b1;
    cyc();
    div_load_i = 1'b0;
    tests_run++;
    if ({busy_o, div_cur_o} !== {1'b1, 16'd500}) begin tests_failed++; $display("FAIL odd_load_busy: got busy=%b cur=%0d expected 1 500", busy_o, div_cur_o); end
    n = 0;
    while (busy_o && n < 600) begin cyc(); n++; end
    tests_run++;
    if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL odd_apply_timeout: got busy=%b expected 0", busy_o); end
    tests_run++;
    if ({tick_o, clk_o, div_cur_o} !== {1'b1, 1'b1, 16'd3}) begin tests_failed++; $display("FAIL odd_apply_at_wrap: got tick=%b clk=%b cur=%0d expected 1 1 3", tick_o, clk_o, div_cur_o); end
    repeat (10) cyc();
    tests_run++;
    if ((last_rise - prev_rise) !== 64'd60) begin tests_failed++; $display("FAIL odd_period_ns: got %0t expected 60", last_rise - prev_rise); end
    tests_run++;
    if (last_high !== 64'd30) begin tests_failed++; $display("FAIL odd_high_ns: got %0t expected 30", last_high); end
    tests_run++;
    if (align_err !== 0) begin tests_failed++; $display("FAIL odd_tick_align: got %0d misaligned expected 0", align_err); end
  endtask

  task automatic test_back_to_back();
    int n;
    div_i = 16'd4; div_load_i = 1'b1;
    cyc();
    tests_run++;
    if (busy_o !== 1'b1) begin tests_failed++; $display("FAIL b2b_first_busy: got %b expected 1", busy_o); end
    div_i = 16'd7;
    cyc();
    div_load_i = 1'b0;
    tests_run++;
    if (div_err_o !== 1'b1) begin tests_failed++; $display("FAIL b2b_err_pulse: got %b expected 1", div_err_o); end
    cyc();
    tests_run++;
    if (div_err_o !== 1'b0) begin tests_failed++; $display("FAIL b2b_err_one_cycle: got %b expected 0", div_err_o); end
    n = 0;
    while (busy_o && n < 20) begin cyc(); n++; end
    tests_run++;
    if ({busy_o, div_cur_o} !== {1'b0, 16'd4}) begin tests_failed++; $display("FAIL b2b_ratio: got busy=%b cur=%0d expected 0 4", busy_o, div_cur_o); end
    repeat (12) cyc();
    tests_run++;
    if ((last_rise - prev_rise) !== 64'd80) begin tests_failed++; $display("FAIL b2b_period_ns: got %0t expected 80", last_rise - prev_rise); end
    tests_run++;
    if ({last_high, div_cur_o} !== {64'd40, 16'd4}) begin tests_failed++; $display("FAIL b2b_high_cur: got high=%0t cur=%0d expected 40 4", last_high, div_cur_o); end
  endtask

  task automatic test_bad_ratio();
    div_i = 16'd1; div_load_i = 1'b1;
    cyc();
    div_load_i = 1'b0;
    tests_run++;
    if ({div_err_o, busy_o} !== 2'b10) begin tests_failed++; $display("FAIL bad1_err_busy: got err=%b busy=%b expected 1 0", div_err_o, busy_o); end
    cyc();
    tests_run++;
    if (div_err_o !== 1'b0) begin tests_failed++; $display("FAIL bad1_err_clear: got %b expected 0", div_err_o); end
    div_i = 16'd0; div_load_i = 1'b1;
    cyc();
    div_load_i = 1'b0;
    tests_run++;
    if ({div_err_o, busy_o} !== 2'b10) begin tests_failed++; $display("FAIL bad0_err_busy: got err=%b busy=%b expected 1 0", div_err_o, busy_o); end
    repeat (5) cyc();
    tests_run++;
    if ({busy_o, div_cur_o} !== {1'b0, 16'd4}) begin tests_failed++; $display("FAIL bad_ratio_cur: got busy=%b cur=%0d expected 0 4", busy_o, div_cur_o); end
  endtask

  task automatic test_enable();
    int  n;
    int  ticks;
    time r0;
    div_i = 16'd6; div_load_i = 1'b1;
    cyc();
    div_load_i = 1'b0;
    n = 0;
    while (busy_o && n < 20) begin cyc(); n++; end
    tests_run++;
    if ({busy_o, div_cur_o} !== {1'b0, 16'd6}) begin tests_failed++; $display("FAIL en_load6: got busy=%b cur=%0d expected 0 6", busy_o, div_cur_o); end
    min_high = 64'd1000000;
    cyc();
    en_i  = 1'b0;
    ticks = 0;
    r0    = last_rise;
    for (int i = 0; i < 14; i++) begin
      cyc();
      if (tick_o) ticks++;
    end
    tests_run++;
    if ({ticks, clk_o} !== {32'd0, 1'b0}) begin tests_failed++; $display("FAIL en_stopped: got ticks=%0d clk=%b expected 0 0", ticks, clk_o); end
    tests_run++;
    if (last_rise !== r0) begin tests_failed++; $display("FAIL en_no_rise: got rise at %0t expected none after %0t", last_rise, r0); end
    en_i = 1'b1;
    cyc();
    tests_run++;
    if ({clk_o, tick_o} !== 2'b11) begin tests_failed++; $display("FAIL en_restart: got clk=%b tick=%b expected 1 1", clk_o, tick_o); end
    repeat (13) cyc();
    tests_run++;
    if (min_high !== 64'd60) begin tests_failed++; $display("FAIL en_min_high_ns: got %0t expected 60", min_high); end
    tests_run++;
    if ((last_rise - prev_rise) !== 64'd120) begin tests_failed++; $display("FAIL en_period_ns: got %0t expected 120", last_rise - prev_rise); end
    tests_run++;
    if (align_err !== 0) begin tests_failed++; $display("FAIL en_tick_align: got %0d misaligned expected 0", align_err); end
  endtask

  task automatic test_reset_midperiod();
    int n;
    div_i = 16'd500; div_load_i = 1'b1;
    cyc();
    div_load_i = 1'b0;
    n = 0;
    while (busy_o && n < 20) begin cyc(); n++; end
    tests_run++;
    if ({busy_o, div_cur_o} !== {1'b0, 16'd500}) begin tests_failed++; $display("FAIL rst_load500: got busy=%b cur=%0d expected 0 500", busy_o, div_cur_o); end
    repeat (248) cyc();
    div_i = 16'd10; div_load_i = 1'b1;
    cyc();
    div_load_i = 1'b0;
    tests_run++;
    if (busy_o !== 1'b1) begin tests_failed++; $display("FAIL rst_pending: got busy=%b expected 1", busy_o); end
    cyc();
    rst_n = 1'b0;
    cyc();
    tests_run++;
    if ({clk_o, tick_o, busy_o, div_cur_o} !== {1'b0, 1'b0, 1'b0, 16'd500}) begin
      tests_failed++;
      $display("FAIL rst_mid_state: got clk=%b tick=%b busy=%b cur=%0d expected 0 0 0 500", clk_o, tick_o, busy_o, div_cur_o);
    end
    cyc();
    rst_n = 1'b1;
    cyc();
    tests_run++;
    if ({clk_o, tick_o} !== 2'b11) begin tests_failed++; $display("FAIL rst_first_rise: got clk=%b tick=%b expected 1 1", clk_o, tick_o); end
    measure_default();
    tests_run++;
    if ({busy_o, div_cur_o} !== {1'b0, 16'd500}) begin tests_failed++; $display("FAIL rst_discarded: got busy=%b cur=%0d expected 0 500", busy_o, div_cur_o); end
  endtask

  initial begin
    test_reset();
    test_load_odd();
    test_back_to_back();
    test_bad_ratio();
    test_enable();
    test_reset_midperiod();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
